// File: rtl/stack_mem_responder.sv
// Memory-port responder for the stack CPU: on-chip RAM, LED capture and stream boot loader.
// Optional feature: define WRITE_PROTECT_EN to block CPU writes to words [0, PROT_WORDS).
module stack_mem_responder #(
    parameter int unsigned AW         = 12,
    parameter int unsigned PROT_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] address,
    input  logic [15:0] wr_data,
    input  logic        wr,
    output logic [15:0] rd_data,
    input  logic [7:0]  leds_in,
    input  logic        lr,
    output logic [7:0]  led_out,
    output logic [7:0]  led_count,
    input  logic        boot_valid,
    input  logic [15:0] boot_data,
    input  logic        boot_last,
    output logic        boot_ready,
    output logic        cpu_run,
    output logic        wp_fault
);

    localparam int unsigned DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] boot_ptr_q, boot_ptr_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic [7:0]    led_out_q, led_out_d;
    logic [7:0]    led_count_q, led_count_d;
    logic          wp_fault_q, wp_fault_d;

    logic [15:0]   mem [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;

    logic [AW-1:0] cpu_addr;
    logic          cpu_in_range;
    logic          cpu_wr_blocked;
    logic          cpu_wr_ok;

    assign cpu_addr     = address[AW-1:0];
    assign cpu_in_range = (address[15:AW] == '0);

`ifdef WRITE_PROTECT_EN
    localparam logic [15:0] PROT_LIMIT = 16'(PROT_WORDS);
    assign cpu_wr_blocked = (state_q == S_RUN) && wr && cpu_in_range && (address < PROT_LIMIT);
`else
    assign cpu_wr_blocked = 1'b0;
`endif

    assign cpu_wr_ok = (state_q == S_RUN) && wr && cpu_in_range && !cpu_wr_blocked;

    always_comb begin
        state_d     = state_q;
        boot_ptr_d  = boot_ptr_q;
        rd_data_d   = '0;
        led_out_d   = led_out_q;
        led_count_d = led_count_q;
        wp_fault_d  = cpu_wr_blocked;
        mem_we      = 1'b0;
        mem_waddr   = boot_ptr_q;
        mem_wdata   = boot_data;

        case (state_q)
            S_IDLE: state_d = S_LOAD;

            S_LOAD: begin
                if (boot_valid) begin
                    mem_we = 1'b1;
                    // The last slot ends the load even without boot_last; the pointer never wraps.
                    if (boot_last || (boot_ptr_q == '1)) begin
                        state_d = S_RUN;
                    end else begin
                        boot_ptr_d = boot_ptr_q + 1'b1;
                    end
                end
            end

            S_RUN: begin
                if (cpu_wr_ok) begin
                    mem_we    = 1'b1;
                    mem_waddr = cpu_addr;
                    mem_wdata = wr_data;
                end
                // Write-first: an accepted write to the word being read bypasses the RAM.
                if (cpu_in_range) begin
                    rd_data_d = cpu_wr_ok ? wr_data : mem[cpu_addr];
                end
                if (lr) begin
                    led_out_d = leds_in;
                    if (led_count_q != '1) begin
                        led_count_d = led_count_q + 1'b1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            boot_ptr_q  <= '0;
            rd_data_q   <= '0;
            led_out_q   <= '0;
            led_count_q <= '0;
            wp_fault_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            boot_ptr_q  <= boot_ptr_d;
            rd_data_q   <= rd_data_d;
            led_out_q   <= led_out_d;
            led_count_q <= led_count_d;
            wp_fault_q  <= wp_fault_d;
        end
    end

    // RAM contents survive reset so a reload simply overwrites them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rd_data    = rd_data_q;
    assign led_out    = led_out_q;
    assign led_count  = led_count_q;
    assign wp_fault   = wp_fault_q;
    assign boot_ready = (state_q == S_LOAD);
    assign cpu_run    = (state_q == S_RUN);

endmodule

// File: tb/tb_stack_mem_responder.sv
// Self-checking bench for stack_mem_responder: directed scenarios plus randomized run traffic
// checked against a behavioural model (phase flag, associative-array RAM, saturating counter).
module tb_stack_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] address, wr_data, rd_data, boot_data;
    logic        wr, lr, boot_valid, boot_last, boot_ready, cpu_run, wp_fault;
    logic [7:0]  leds_in, led_out, led_count;

    stack_mem_responder #(.AW(12), .PROT_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .wr_data(wr_data), .wr(wr),
        .rd_data(rd_data), .leds_in(leds_in), .lr(lr), .led_out(led_out),
        .led_count(led_count), .boot_valid(boot_valid), .boot_data(boot_data),
        .boot_last(boot_last), .boot_ready(boot_ready), .cpu_run(cpu_run), .wp_fault(wp_fault)
    );

    always #5 clk = ~clk;

`ifdef WRITE_PROTECT_EN
    localparam bit WP = 1'b1;
`else
    localparam bit WP = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = waiting after reset, 1 = loading, 2 = running.
    logic [15:0] m_mem [int];
    int          m_phase;
    int          m_ptr;
    logic [15:0] e_rd;
    bit          e_rd_known;
    logic [7:0]  e_led;
    int          e_cnt;
    bit          e_wp;

    logic [15:0] boot_words [4];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        if (e_rd_known) chk({tag, ".rd_data"}, rd_data, e_rd);
        chk({tag, ".led_out"}, {8'h0, led_out}, {8'h0, e_led});
        chk({tag, ".led_count"}, {8'h0, led_count}, 16'(e_cnt));
        chk({tag, ".boot_ready"}, {15'h0, boot_ready}, {15'h0, m_phase == 1});
        chk({tag, ".cpu_run"}, {15'h0, cpu_run}, {15'h0, m_phase == 2});
        chk({tag, ".wp_fault"}, {15'h0, wp_fault}, {15'h0, e_wp});
    endtask

    task automatic clear_inputs();
        address = '0; wr_data = '0; wr = 1'b0; leds_in = '0; lr = 1'b0;
        boot_valid = 1'b0; boot_data = '0; boot_last = 1'b0;
    endtask

    // One clock: predict from the current inputs, advance, compare.
    task automatic step(input string tag);
        int  a;
        bit  inr, prot;
        a    = int'(address);
        inr  = (a < 4096);
        prot = WP && (a < 256);
        e_wp = 1'b0;
        if (m_phase == 2) begin
            if (!inr) begin
                e_rd = '0; e_rd_known = 1'b1;
            end else if (wr && !prot) begin
                e_rd = wr_data; e_rd_known = 1'b1;
            end else if (m_mem.exists(a)) begin
                e_rd = m_mem[a]; e_rd_known = 1'b1;
            end else begin
                e_rd_known = 1'b0;
            end
            if (wr && inr && prot) e_wp = 1'b1;
            if (wr && inr && !prot) m_mem[a] = wr_data;
            if (lr) begin
                e_led = leds_in;
                if (e_cnt < 255) e_cnt++;
            end
        end else begin
            e_rd = '0; e_rd_known = 1'b1;
            if (m_phase == 0) begin
                m_phase = 1;
            end else if (boot_valid) begin
                m_mem[m_ptr] = boot_data;
                if (boot_last || m_ptr == 4095) m_phase = 2;
                else m_ptr++;
            end
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset asserted away from the clock edge; outputs must clear at once.
    task automatic hard_reset();
        rst_n = 1'b0;
        #1;
        m_phase = 0; m_ptr = 0; e_rd = '0; e_rd_known = 1'b1;
        e_led = '0; e_cnt = 0; e_wp = 1'b0;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic boot_word(input logic [15:0] d, input bit last);
        boot_valid = 1'b1; boot_data = d; boot_last = last;
        step("boot");
        boot_valid = 1'b0; boot_last = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        address = a; wr = 1'b0;
        step("read");
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        address = a; wr_data = d; wr = 1'b1;
        step("write");
        wr = 1'b0;
    endtask

    initial begin
        boot_words[0] = 16'h8005; boot_words[1] = 16'h8003;
        boot_words[2] = 16'h0100; boot_words[3] = 16'h0000;
        clear_inputs();
        rst_n = 1'b1;
        #3;
        hard_reset();
        step("idle");

        // Short boot, then readback with one-cycle latency.
        for (int i = 0; i < 4; i++) boot_word(boot_words[i], i == 3);
        chk("t1_boot_ready_low", {15'h0, boot_ready}, 16'h0);
        chk("t1_cpu_run", {15'h0, cpu_run}, 16'h1);
        for (int i = 0; i < 4; i++) begin
            cpu_read(16'(i));
            chk($sformatf("t1_read%0d", i), rd_data, boot_words[i]);
        end

        // Write-first collision.
        cpu_write(16'h0200, 16'hBEEF);
        chk("t2_collision", rd_data, 16'hBEEF);
        cpu_read(16'h0200);
        chk("t2_readback", rd_data, 16'hBEEF);

        // Out-of-range address.
        cpu_read(16'h7000);
        chk("t3_oor_read", rd_data, 16'h0000);
        cpu_write(16'h7000, 16'h5A5A);
        cpu_read(16'h0000);
        chk("t3_word0_kept", rd_data, 16'h8005);

        // LED capture and saturation.
        for (int i = 1; i <= 3; i++) begin
            leds_in = 8'(8'h11 * i); lr = 1'b1;
            step("led");
            lr = 1'b0;
            step("led_gap");
        end
        chk("t4_led_out", {8'h0, led_out}, 16'h0033);
        chk("t4_led_count", {8'h0, led_count}, 16'd3);
        lr = 1'b1;
        for (int i = 0; i < 300; i++) begin
            leds_in = 8'($urandom);
            step("led_hold");
        end
        lr = 1'b0;
        chk("t4_led_sat", {8'h0, led_count}, 16'd255);

        // Reset mid-boot, then reload restarting at word 0.
        hard_reset();
        step("idle2");
        boot_word(16'h1111, 1'b0);
        boot_word(16'h2222, 1'b0);
        hard_reset();
        chk("t5_cpu_run_low", {15'h0, cpu_run}, 16'h0);
        step("idle3");
        boot_word(16'h3333, 1'b1);
        cpu_read(16'h0000);
        chk("t5_word0_over", rd_data, 16'h3333);
        cpu_read(16'h0001);
        chk("t5_word1_left", rd_data, 16'h2222);

        // Full-depth boot: boot_last coincides with the final slot; gaps in valid.
        hard_reset();
        step("idle4");
        for (int i = 0; i < 4096; i++) begin
            if ($urandom_range(0, 7) == 0) step("boot_gap");
            boot_word(16'($urandom), i == 4095);
        end
        chk("full_boot_run", {15'h0, cpu_run}, 16'h1);
        boot_valid = 1'b1; boot_data = 16'hDEAD; boot_last = 1'b1;
        step("boot_after_run");
        clear_inputs();
        cpu_read(16'h0000);

        // Write protection of the low region.
        cpu_write(16'h0010, 16'h1234);
        chk("t6_fault", {15'h0, wp_fault}, {15'h0, WP});
        cpu_read(16'h0010);
        chk("t6_fault_cleared", {15'h0, wp_fault}, 16'h0);
        if (!WP) chk("t6_written", rd_data, 16'h1234);
        cpu_write(16'h0100, 16'h4321);
        chk("t6_no_fault", {15'h0, wp_fault}, 16'h0);
        cpu_read(16'h0100);
        chk("t6_unprot", rd_data, 16'h4321);

        // Randomized run traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       address = 16'(16'h1000 + $urandom_range(0, 16'hEFFF));
                1, 2:    address = 16'($urandom_range(0, 300));
                default: address = 16'($urandom_range(0, 4095));
            endcase
            wr      = ($urandom_range(0, 2) == 0);
            wr_data = 16'($urandom);
            lr      = ($urandom_range(0, 4) == 0);
            leds_in = 8'($urandom);
            step("rand");
        end
        clear_inputs();
        step("tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
